// File: rtl/virtual_jtag_adda_rdbk_if.sv
// -----------------------------------------------------------------------------
// virtual_jtag_adda_rdbk_if
// Bundles the readback FIFO write port and the virtual JTAG pins.
//   Write side : wr_en, wr_data (to block), full, empty (from block)
//   JTAG side  : tck, tdi, ir_in, v_cdr, v_sdr (to block), tdo (from block)
// master : the driver of writes and JTAG traffic (design logic / host model)
// slave  : the readback block itself
// -----------------------------------------------------------------------------
interface virtual_jtag_adda_rdbk_if #(
   parameter int data_width = 32
);
   logic                  wr_en;
   logic [data_width-1:0] wr_data;
   logic                  full;
   logic                  empty;
   logic                  tck;
   logic                  tdi;
   logic [1:0]            ir_in;
   logic                  v_cdr;
   logic                  v_sdr;
   logic                  tdo;

   modport master (
      output wr_en, wr_data, tck, tdi, ir_in, v_cdr, v_sdr,
      input  full, empty, tdo
   );

   modport slave (
      input  wr_en, wr_data, tck, tdi, ir_in, v_cdr, v_sdr,
      output full, empty, tdo
   );
endinterface

// File: rtl/virtual_jtag_adda_rdbk.sv
// -----------------------------------------------------------------------------
// virtual_jtag_adda_rdbk
// Readback FIFO drained through a virtual JTAG data register. Design logic
// pushes words in the clk domain; a JTAG host selects rd_instr, captures the
// oldest word (plus valid and sticky-overflow bits) and shifts it out on tdo.
// All JTAG pins are oversampled in clk (clk >= 8x tck).
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport of virtual_jtag_adda_rdbk_if (write port + JTAG pins)
// Parameters:
//   data_width : readback word width
//   fifo_depth : FIFO entries, power of 2, >= 2
//   rd_instr   : virtual IR code selecting the readback register
// -----------------------------------------------------------------------------
module virtual_jtag_adda_rdbk #(
   parameter int         data_width = 32,
   parameter int         fifo_depth = 8,
   parameter logic [1:0] rd_instr   = 2'b10
) (
   input logic                     clk,
   input logic                     rst_n,
   virtual_jtag_adda_rdbk_if.slave bus
);
   localparam int ptr_w = $clog2(fifo_depth);
   localparam int cnt_w = ptr_w + 1;
   localparam int sr_w  = data_width + 2;

   // Stages [0] and [1] resolve metastability; [2] holds the pre-edge value.
   logic [2:0]      tck_q, tdi_q, cdr_q, sdr_q;
   logic [2:0][1:0] ir_q;

   logic [data_width-1:0] mem_q [fifo_depth];
   logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0]      count_q, count_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  ovf_q, ovf_d;
   logic [sr_w-1:0]       sr_q, sr_d;
   logic                  bypass_q, bypass_d;
   logic                  tdo_q, tdo_d;

   logic tck_rise, sel, capture, shift, pop, push, drop;

   // Qualifiers come from stage [2] so they reflect the state before tck rose.
   assign tck_rise = tck_q[1] & ~tck_q[2];
   assign sel      = (ir_q[2] == rd_instr);
   assign capture  = tck_rise & sel & cdr_q[2];
   assign shift    = tck_rise & sel & sdr_q[2] & ~capture;
   assign pop      = capture & ~empty_q;
   // A capture pop frees a slot in the same clk, so a write while full is kept.
   assign push     = bus.wr_en & (~full_q | pop);
   assign drop     = bus.wr_en & full_q & ~pop;

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path through this block can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      sr_d     = sr_q;
      bypass_d = bypass_q;

      if (push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
      count_d = count_q + cnt_w'(push) - cnt_w'(pop);

      // A dropped write wins over the clear-on-capture.
      if (drop)         ovf_d = 1'b1;
      else if (capture) ovf_d = 1'b0;

      if (capture) begin
         if (!empty_q) sr_d = {mem_q[rd_ptr_q], ovf_q, 1'b1};
         else          sr_d = {{data_width{1'b0}}, ovf_q, 1'b0};
      end else if (shift) begin
         sr_d = {tdi_q[2], sr_q[sr_w-1:1]};
      end

      if (tck_rise) bypass_d = tdi_q[2];

      full_d  = (count_d == cnt_w'(fifo_depth));
      empty_d = (count_d == '0);
      tdo_d   = sel ? sr_q[0] : bypass_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         tck_q    <= '0;
         tdi_q    <= '0;
         cdr_q    <= '0;
         sdr_q    <= '0;
         ir_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         sr_q     <= '0;
         bypass_q <= 1'b0;
         tdo_q    <= 1'b0;
      end else begin
         tck_q    <= {tck_q[1:0], bus.tck};
         tdi_q    <= {tdi_q[1:0], bus.tdi};
         cdr_q    <= {cdr_q[1:0], bus.v_cdr};
         sdr_q    <= {sdr_q[1:0], bus.v_sdr};
         ir_q     <= {ir_q[1:0], bus.ir_in};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         sr_q     <= sr_d;
         bypass_q <= bypass_d;
         tdo_q    <= tdo_d;
      end
   end

   // NOTE: storage has no reset; reset empties the FIFO through the pointers and count, so stale words are never read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.full  = full_q;
   assign bus.empty = empty_q;
   assign bus.tdo   = tdo_q;
endmodule

// File: tb/tb_virtual_jtag_adda_rdbk.sv
// -----------------------------------------------------------------------------
// tb_virtual_jtag_adda_rdbk
// Directed bench for virtual_jtag_adda_rdbk (data_width 32, fifo_depth 8).
// tck runs at 10 clk per period; tdo is sampled late in the tck-low phase, so
// each sample shows the value produced by the previous tck rise.
// -----------------------------------------------------------------------------
module tb_virtual_jtag_adda_rdbk;
   localparam int DW  = 32;
   localparam int SRW = DW + 2;

   logic clk;
   logic rst_n;
   int   total  = 0;
   int   passed = 0;

   virtual_jtag_adda_rdbk_if #(.data_width(DW)) bus ();

   virtual_jtag_adda_rdbk #(
      .data_width(DW),
      .fifo_depth(8),
      .rd_instr  (2'b10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      bus.wr_en   = 1'b1;
      bus.wr_data = w;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
   endtask

   // One tck period. tdo_s is sampled just before tck rises. With bb set,
   // 0xBB is written in exactly the clk in which this rise is detected.
   task automatic tck_pulse(input logic tdi_v, input logic cdr, input logic sdr,
                            input logic bb, output logic tdo_s);
      bus.tdi   = tdi_v;
      bus.v_cdr = cdr;
      bus.v_sdr = sdr;
      repeat (5) @(posedge clk);
      #1;
      tdo_s   = bus.tdo;
      bus.tck = 1'b1;
      for (int j = 0; j < 5; j++) begin
         if (bb && j == 2) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 32'hBB;
         end
         @(posedge clk); #1;
         if (j == 2) bus.wr_en = 1'b0;
      end
      bus.tck = 1'b0;
   endtask

   // Capture followed by nshift shift cycles; bits[i] is the i-th tdo bit out.
   task automatic scan(input int nshift, input logic bb, output logic [SRW-1:0] bits);
      logic t;
      bits = '0;
      tck_pulse(1'b0, 1'b1, 1'b0, bb, t);
      for (int i = 0; i < nshift; i++) begin
         tck_pulse(1'b0, 1'b0, 1'b1, 1'b0, t);
         if (i < SRW) bits[i] = t;
      end
      bus.v_cdr = 1'b0;
      bus.v_sdr = 1'b0;
   endtask

   initial begin
      logic [SRW-1:0] b;
      logic [3:0]     byp;
      logic           t;
      logic [DW-1:0]  exp_q [8];

      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.tck     = 1'b0;
      bus.tdi     = 1'b0;
      bus.ir_in   = 2'b10;
      bus.v_cdr   = 1'b0;
      bus.v_sdr   = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tdo",   bus.tdo,   1'b0);
      check("reset_empty", bus.empty, 1'b1);
      check("reset_full",  bus.full,  1'b0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Two words, capture and shift the oldest.
      push_word(32'h11111111);
      push_word(32'h22222222);
      check("two_push_empty", bus.empty, 1'b0);
      scan(34, 1'b0, b);
      check("rd1_valid", b[0], 1'b1);
      check("rd1_ovf",   b[1], 1'b0);
      check("rd1_data",  b[SRW-1:2], 32'h11111111);
      check("rd1_empty", bus.empty, 1'b0);
      scan(34, 1'b0, b);
      check("rd2_stream", b, {32'h22222222, 1'b0, 1'b1});
      check("rd2_empty",  bus.empty, 1'b1);

      // Capture on an empty FIFO.
      scan(34, 1'b0, b);
      check("empty_stream", b, '0);
      check("empty_stays",  bus.empty, 1'b1);

      // Overflow: nine pushes into eight entries.
      for (int i = 0; i < 9; i++) begin
         push_word(32'hA0 + i);
         if (i == 6) check("full_after_7", bus.full, 1'b0);
         if (i == 7) check("full_after_8", bus.full, 1'b1);
      end
      check("full_after_9", bus.full, 1'b1);
      scan(34, 1'b0, b);
      check("ovf_rd_stream", b, {32'hA0, 1'b1, 1'b1});
      check("ovf_rd_full",   bus.full, 1'b0);
      scan(34, 1'b0, b);
      check("ovf_cleared_stream", b, {32'hA1, 1'b0, 1'b1});

      // Refill to full, then write 0xBB in the same clk as a capture pop.
      push_word(32'hC0);
      push_word(32'hC1);
      check("refill_full", bus.full, 1'b1);
      scan(34, 1'b1, b);
      check("pop_push_stream", b, {32'hA2, 1'b0, 1'b1});
      check("pop_push_full",   bus.full, 1'b1);
      exp_q = '{32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hC0, 32'hC1, 32'hBB};
      for (int i = 0; i < 8; i++) begin
         scan(34, 1'b0, b);
         check($sformatf("drain%0d", i), b, {exp_q[i], 1'b0, 1'b1});
      end
      check("drain_empty", bus.empty, 1'b1);

      // Bypass path with another instruction; FIFO must be untouched.
      push_word(32'h33);
      bus.ir_in = 2'b01;
      tck_pulse(1'b1, 1'b0, 1'b1, 1'b0, t);
      tck_pulse(1'b0, 1'b0, 1'b1, 1'b0, byp[3]);
      tck_pulse(1'b1, 1'b0, 1'b1, 1'b0, byp[2]);
      tck_pulse(1'b1, 1'b0, 1'b1, 1'b0, byp[1]);
      tck_pulse(1'b0, 1'b0, 1'b1, 1'b0, byp[0]);
      bus.v_sdr = 1'b0;
      check("bypass_pattern", byp, 4'b1011);
      check("bypass_empty",   bus.empty, 1'b0);
      check("bypass_full",    bus.full, 1'b0);
      bus.ir_in = 2'b10;
      scan(34, 1'b0, b);
      check("after_bypass_stream", b, {32'h33, 1'b0, 1'b1});

      // Reset in the middle of a scan with overflow set and words queued.
      for (int i = 0; i < 9; i++) push_word(32'hD0 + i);
      tck_pulse(1'b0, 1'b1, 1'b0, 1'b0, t);
      push_word(32'hE0);
      push_word(32'hE1);
      for (int i = 0; i < 10; i++) tck_pulse(1'b1, 1'b0, 1'b1, 1'b0, t);
      bus.v_sdr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midscan_rst_tdo",   bus.tdo,   1'b0);
      check("midscan_rst_empty", bus.empty, 1'b1);
      check("midscan_rst_full",  bus.full,  1'b0);
      repeat (2) @(posedge clk);
      #1;
      scan(34, 1'b0, b);
      check("post_rst_stream", b, '0);
      check("post_rst_empty",  bus.empty, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
